// File: rtl/teclado_pkg.sv
// Shared PS/2 scancode constants and decoder state encoding.
package teclado_pkg;

    localparam logic [7:0] ENTER = 8'h5A;
    localparam logic [7:0] OFF   = 8'h29;
    localparam logic [7:0] TEMP  = 8'h2C;
    localparam logic [7:0] SMOKE = 8'h33;
    localparam logic [7:0] BRK   = 8'hF0;
    localparam logic [7:0] EXT   = 8'hE0;

    localparam logic [7:0] DIG_0 = 8'h45;
    localparam logic [7:0] DIG_1 = 8'h16;
    localparam logic [7:0] DIG_2 = 8'h1E;
    localparam logic [7:0] DIG_3 = 8'h26;
    localparam logic [7:0] DIG_4 = 8'h25;
    localparam logic [7:0] DIG_5 = 8'h2E;
    localparam logic [7:0] DIG_6 = 8'h36;
    localparam logic [7:0] DIG_7 = 8'h3D;
    localparam logic [7:0] DIG_8 = 8'h3E;
    localparam logic [7:0] DIG_9 = 8'h46;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DIGIT = 2'd2
    } estado_t;

endpackage

// File: rtl/decodificador_comandos_tecla_a_digito.sv
// Combinational scancode to decimal digit lookup; zero latency, no backpressure.
module tecla_a_digito
    import teclado_pkg::*;
(
    input  logic [7:0] i_code,
    output logic       o_is_digit,
    output logic [3:0] o_value
);

    always_comb begin
        o_is_digit = 1'b1;
        o_value    = 4'd0;
        case (i_code)
            DIG_0:   o_value = 4'd0;
            DIG_1:   o_value = 4'd1;
            DIG_2:   o_value = 4'd2;
            DIG_3:   o_value = 4'd3;
            DIG_4:   o_value = 4'd4;
            DIG_5:   o_value = 4'd5;
            DIG_6:   o_value = 4'd6;
            DIG_7:   o_value = 4'd7;
            DIG_8:   o_value = 4'd8;
            DIG_9:   o_value = 4'd9;
            default: o_is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/decodificador_comandos.sv
// Keyboard command decoder: arms on Enter, sets mode and 1-2 digit current setpoint.
// Latency 1 cycle from key_valid; accepts a byte every cycle, no backpressure.
module decodificador_comandos
    import teclado_pkg::*;
#(
    parameter int CUR_MAX     = 99,
    parameter int CUR_W       = 7,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [7:0]       key_code,
    output logic             armed,
    output logic             temp_en,
    output logic             smoke_en,
    output logic [CUR_W-1:0] cur_val,
    output logic             cur_load,
    output logic             err
);

    localparam int               CNT_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [6:0]       CUR_MAX_7 = 7'(CUR_MAX);

    estado_t          r_state;
    logic             r_brk_pend;
    logic [3:0]       r_tens;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_temp_en;
    logic             r_smoke_en;
    logic [CUR_W-1:0] r_cur_val;
    logic             r_cur_load;
    logic             r_err;

    logic       w_is_digit;
    logic [3:0] w_digit;
    logic [6:0] w_sum;
    logic       w_sat;
    logic [6:0] w_clamped;
    logic       w_cmd;
    logic       w_to_idle;

    tecla_a_digito u_tecla_a_digito (
        .i_code     (key_code),
        .o_is_digit (w_is_digit),
        .o_value    (w_digit)
    );

    assign w_sum     = ({3'b000, r_tens} * 7'd10) + {3'b000, w_digit};
    assign w_sat     = (w_sum > CUR_MAX_7);
    assign w_clamped = w_sat ? CUR_MAX_7 : w_sum;

    // A byte is a command only if it is not swallowed as a release code or prefix.
    assign w_cmd     = key_valid && !r_brk_pend && (key_code != BRK) && (key_code != EXT);
    // Off and idle expiry share one exit path; a key on the expiry edge cancels the timeout.
    assign w_to_idle = (r_state != ST_IDLE) &&
                       ((w_cmd && (key_code == OFF)) ||
                        (!key_valid && (r_cnt == CNT_LAST)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_brk_pend <= 1'b0;
            r_tens     <= 4'd0;
            r_cnt      <= '0;
            r_armed    <= 1'b0;
            r_temp_en  <= 1'b0;
            r_smoke_en <= 1'b0;
            r_cur_val  <= '0;
            r_cur_load <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cur_load <= 1'b0;
            r_err      <= 1'b0;
            if (w_to_idle) begin
                r_state    <= ST_IDLE;
                r_brk_pend <= 1'b0;
                r_tens     <= 4'd0;
                r_cnt      <= '0;
                r_armed    <= 1'b0;
                r_temp_en  <= 1'b0;
                r_smoke_en <= 1'b0;
                r_cur_val  <= '0;
            end else if (key_valid) begin
                r_cnt <= '0;
                if (r_brk_pend) begin
                    r_brk_pend <= 1'b0;
                end else if (key_code == BRK) begin
                    r_brk_pend <= 1'b1;
                end else if (w_cmd) begin
                    case (r_state)
                        ST_IDLE: begin
                            if (key_code == ENTER) begin
                                r_state <= ST_ARMED;
                                r_armed <= 1'b1;
                            end
                        end
                        ST_ARMED: begin
                            if (key_code == TEMP) begin
                                r_temp_en  <= 1'b1;
                                r_smoke_en <= 1'b0;
                            end else if (key_code == SMOKE) begin
                                r_smoke_en <= 1'b1;
                                r_temp_en  <= 1'b0;
                            end else if (w_is_digit) begin
                                r_tens  <= w_digit;
                                r_state <= ST_DIGIT;
                            end
                        end
                        ST_DIGIT: begin
                            r_state <= ST_ARMED;
                            if (w_is_digit) begin
                                r_cur_val  <= CUR_W'(w_clamped);
                                r_cur_load <= 1'b1;
                                r_err      <= w_sat;
                            end else if (key_code == ENTER) begin
                                r_cur_val  <= CUR_W'(r_tens);
                                r_cur_load <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_armed <= 1'b0;
                        end
                    endcase
                end
            end else if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign armed    = r_armed;
    assign temp_en  = r_temp_en;
    assign smoke_en = r_smoke_en;
    assign cur_val  = r_cur_val;
    assign cur_load = r_cur_load;
    assign err      = r_err;

endmodule

// File: tb/tb_decodificador_comandos.sv
// Bench for decodificador_comandos: two instances (CUR_MAX 99 and 50) against a behavioural model.
module tb_decodificador_comandos;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [7:0] key_code;

    logic       a_armed, a_temp, a_smoke, a_load, a_err;
    logic [6:0] a_cur;
    logic       b_armed, b_temp, b_smoke, b_load, b_err;
    logic [5:0] b_cur;

    int tests = 0;
    int fails = 0;

    decodificador_comandos #(.CUR_MAX(99), .CUR_W(7), .TIMEOUT_CYC(8)) dut_a (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .armed(a_armed), .temp_en(a_temp), .smoke_en(a_smoke),
        .cur_val(a_cur), .cur_load(a_load), .err(a_err)
    );

    decodificador_comandos #(.CUR_MAX(50), .CUR_W(6), .TIMEOUT_CYC(8)) dut_b (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .armed(b_armed), .temp_en(b_temp), .smoke_en(b_smoke),
        .cur_val(b_cur), .cur_load(b_load), .err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: armed, a tens digit pending, release pending, idle edges since last key.
    typedef struct {
        bit armed;
        bit pend;
        bit brk;
        bit temp;
        bit smoke;
        bit load;
        bit err;
        int tens;
        int idle;
        int cur;
    } mdl_t;

    mdl_t m_a, m_b;

    function automatic int digit_of(logic [7:0] c);
        logic [7:0] codes [10];
        codes = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 10; i++)
            if (codes[i] == c) return i;
        return -1;
    endfunction

    function automatic mdl_t step(mdl_t m, bit kv, logic [7:0] kc, int cmax, int tmo);
        mdl_t n;
        mdl_t off;
        int   d;
        int   v;
        off  = '{default: 0};
        n    = m;
        n.load = 0;
        n.err  = 0;
        d    = digit_of(kc);
        if (kv) begin
            n.idle = 0;
            if (m.brk)              n.brk = 0;
            else if (kc == 8'hF0)   n.brk = 1;
            else if (kc == 8'hE0)   n.brk = 0;
            else if (!m.armed) begin
                if (kc == 8'h5A) n.armed = 1;
            end else if (kc == 8'h29) begin
                n = off;
            end else if (!m.pend) begin
                if (kc == 8'h2C)      begin n.temp = 1; n.smoke = 0; end
                else if (kc == 8'h33) begin n.smoke = 1; n.temp = 0; end
                else if (d >= 0)      begin n.pend = 1; n.tens = d; end
            end else begin
                n.pend = 0;
                if (d >= 0) begin
                    v      = m.tens * 10 + d;
                    n.cur  = (v > cmax) ? cmax : v;
                    n.err  = (v > cmax);
                    n.load = 1;
                end else if (kc == 8'h5A) begin
                    n.cur  = m.tens;
                    n.load = 1;
                end else begin
                    n.err = 1;
                end
            end
        end else if (m.armed) begin
            n.idle = m.idle + 1;
            if (n.idle >= tmo) n = off;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_a <= '{default: 0};
            m_b <= '{default: 0};
        end else begin
            m_a <= step(m_a, key_valid, key_code, 99, 8);
            m_b <= step(m_b, key_valid, key_code, 50, 8);
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cmp("rst_a_armed", int'(a_armed), 0);
            cmp("rst_a_temp",  int'(a_temp),  0);
            cmp("rst_a_smoke", int'(a_smoke), 0);
            cmp("rst_a_cur",   int'(a_cur),   0);
            cmp("rst_a_load",  int'(a_load),  0);
            cmp("rst_a_err",   int'(a_err),   0);
            cmp("rst_b_armed", int'(b_armed), 0);
            cmp("rst_b_cur",   int'(b_cur),   0);
        end else begin
            cmp("a_armed", int'(a_armed), int'(m_a.armed));
            cmp("a_temp",  int'(a_temp),  int'(m_a.temp));
            cmp("a_smoke", int'(a_smoke), int'(m_a.smoke));
            cmp("a_cur",   int'(a_cur),   m_a.cur);
            cmp("a_load",  int'(a_load),  int'(m_a.load));
            cmp("a_err",   int'(a_err),   int'(m_a.err));
            cmp("b_armed", int'(b_armed), int'(m_b.armed));
            cmp("b_temp",  int'(b_temp),  int'(m_b.temp));
            cmp("b_smoke", int'(b_smoke), int'(m_b.smoke));
            cmp("b_cur",   int'(b_cur),   m_b.cur);
            cmp("b_load",  int'(b_load),  int'(m_b.load));
            cmp("b_err",   int'(b_err),   int'(m_b.err));
            cmp("excl_a",  int'(a_temp & a_smoke), 0);
        end
    end

    // Called at a falling edge; leaves the strobe for exactly one rising edge.
    task automatic send(input logic [7:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 8'h00;
        idle(2);
        reset = 1'b0;
        idle(1);

        send(8'h5A); send(8'h2C);
        cmp("lit_arm_armed", int'(a_armed), 1);
        cmp("lit_arm_temp",  int'(a_temp),  1);
        cmp("lit_arm_smoke", int'(a_smoke), 0);

        send(8'h26); send(8'h2E);
        cmp("lit_35_cur",  int'(a_cur),  35);
        cmp("lit_35_load", int'(a_load), 1);
        cmp("lit_35_err",  int'(a_err),  0);
        idle(1);
        cmp("lit_35_pulse", int'(a_load), 0);

        send(8'h1E); send(8'h5A);
        cmp("lit_2_cur",  int'(a_cur),  2);
        cmp("lit_2_load", int'(a_load), 1);

        send(8'h36); send(8'h16);
        cmp("lit_61_a_cur", int'(a_cur), 61);
        cmp("lit_61_a_err", int'(a_err), 0);
        cmp("lit_sat_b_cur",  int'(b_cur),  50);
        cmp("lit_sat_b_load", int'(b_load), 1);
        cmp("lit_sat_b_err",  int'(b_err),  1);

        send(8'hF0); send(8'h33);
        cmp("lit_brk_temp",  int'(a_temp),  1);
        cmp("lit_brk_smoke", int'(a_smoke), 0);
        send(8'h33);
        cmp("lit_smoke_s", int'(a_smoke), 1);
        cmp("lit_smoke_t", int'(a_temp),  0);

        send(8'hE0); send(8'h2C);
        cmp("lit_ext_temp", int'(a_temp), 1);

        send(8'h16); send(8'h2C);
        cmp("lit_bad_err",  int'(a_err),  1);
        cmp("lit_bad_load", int'(a_load), 0);
        cmp("lit_bad_cur",  int'(a_cur),  61);

        send(8'h26); send(8'h2E);
        send(8'h16); send(8'h29);
        cmp("lit_off_armed", int'(a_armed), 0);
        cmp("lit_off_temp",  int'(a_temp),  0);
        cmp("lit_off_cur",   int'(a_cur),   0);
        cmp("lit_off_load",  int'(a_load),  0);
        idle(1);

        send(8'hF0); send(8'h5A);
        cmp("lit_idle_brk", int'(a_armed), 0);
        send(8'h5A);
        cmp("lit_rearm", int'(a_armed), 1);
        idle(7);
        cmp("lit_to_before", int'(a_armed), 1);
        idle(1);
        cmp("lit_to_after", int'(a_armed), 0);

        send(8'h5A);
        idle(7);
        send(8'h2C);
        cmp("lit_exp_key_armed", int'(a_armed), 1);
        cmp("lit_exp_key_temp",  int'(a_temp),  1);
        idle(7);
        cmp("lit_exp_restart", int'(a_armed), 1);
        idle(1);
        cmp("lit_exp_fall", int'(a_armed), 0);

        send(8'h5A); send(8'h26);
        idle(8);
        cmp("lit_dig_to", int'(a_armed), 0);

        send(8'h5A); send(8'h26);
        #2 reset = 1'b1;
        #1 cmp("lit_async_rst", int'(a_armed), 0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h5A); send(8'h5A);
        cmp("lit_rst_lost_load", int'(a_load), 0);
        cmp("lit_rst_lost_cur",  int'(a_cur),  0);
        send(8'h2E); send(8'h5A);
        cmp("lit_single_5", int'(a_cur), 5);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decodificador_comandos.md
# decodificador_comandos

Parametrised keyboard command decoder that sits between the PS/2 scancode receiver and the temperature, smoke and current-control datapaths. It arms on Enter and accepts mode commands and one- or two-digit current setpoints. It discards key-release (break) sequences and disarms on an Off key or an idle timeout. All outputs are registered and held between commands.

## Interface
Parameters:
- CUR_MAX, 99: maximum current setpoint; legal range 1..99.
- CUR_W, 7: width of cur_val; must satisfy 2^CUR_W > CUR_MAX.
- TIMEOUT_CYC, 50_000_000: idle clock cycles in ARMED/DIGIT before automatic disarm; must be ≥ 2.

Ports (reset reset, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe, one per received scancode byte
- key_code  in  8  scancode byte; sampled only when key_valid=1
- armed  out  1  high in ARMED or DIGIT
- temp_en  out  1  temperature mode selected (level)
- smoke_en  out  1  smoke mode selected (level); never high together with temp_en
- cur_val  out  CUR_W  last committed current setpoint
- cur_load  out  1  one-cycle pulse when cur_val is updated
- err  out  1  one-cycle pulse on a rejected or saturated entry

## Operation
- States: IDLE, ARMED, DIGIT. Orthogonal flag brk_pend.
- Any state, key_valid with 0xF0: set brk_pend, no other effect. Next key_valid byte: discarded, brk_pend cleared.
- Any state, 0xE0 (extended prefix): ignored. Does not set brk_pend.
- IDLE: 0x5A (Enter) goes to ARMED. All other codes are ignored.
- ARMED:
  - 0x2C: temp_en=1, smoke_en=0.
  - 0x33: smoke_en=1, temp_en=0.
  - Digit key: store it in tens register and go to DIGIT.
  - 0x29 (Off): go to IDLE.
  - Other codes are ignored.
- DIGIT:
  - Digit key: v = tens*10 + units. cur_val = min(v, CUR_MAX), cur_load=1, err=1 if v > CUR_MAX. Go to ARMED.
  - 0x5A: cur_val = tens (single-digit entry), cur_load=1. Go to ARMED.
  - 0x29: go to IDLE and discard the pending digit.
  - Any other code: err=1, discard the pending digit, go to ARMED.
- Digit scancodes: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
- Entering IDLE (by Off or timeout) clears temp_en, smoke_en, cur_val and brk_pend. It does not pulse cur_load.
- Arithmetic: tens*10 + units computed on 7 bits unsigned (max 99), then clamped and truncated to CUR_W.
- Timeout counter:
  - Runs only in ARMED and DIGIT. Cleared on every key_valid and on entry to IDLE.
  - When it reaches TIMEOUT_CYC-1 with no key_valid, the next edge goes to IDLE.
  - Saturates and does not wrap.

## Timing
- Reset values: state IDLE; armed, temp_en, smoke_en, cur_load and err = 0; cur_val = 0; brk_pend = 0; counter = 0.
- Latency: 1 cycle. The edge that samples key_valid=1 updates state and outputs, so they are visible in the following cycle.
- cur_load and err are high for exactly one cycle. They may be high in the same cycle (saturated entry).
- Back-to-back key_valid on consecutive cycles must be handled with no byte lost.
- key_valid and timeout expiry on the same edge: the key is processed and the timeout is cancelled.
- Reset asserted mid-entry: immediate return to reset values. The pending tens digit is lost.

## Structure
- Package teclado_pkg: scancode constants (ENTER, OFF, TEMP, SMOKE, BRK, EXT, ten digit codes) and the state enum.
- Sub-module tecla_a_digito: combinational scancode→{is_digit, value[3:0]} lookup.
- Top module: FSM, brk_pend flag, tens register, timeout counter, output registers.

## Test plan
- Reset, then 0x5A, 0x2C → armed=1 and temp_en=1 one cycle after the 0x2C strobe; smoke_en=0.
- Armed; send 0x26, 0x2E → cur_val=35, cur_load pulses once, err=0.
- Armed; send 0x1E, 0x5A → cur_val=2, cur_load pulses once. Repeat with CUR_MAX=50 and keys 0x36, 0x16 → cur_val=50, cur_load=1 and err=1 in the same cycle.
- Armed; send 0xF0, 0x2C, then 0x33 → the release byte does not change the mode; after 0x33, smoke_en=1 and temp_en=0.
- Armed with temp_en=1, cur_val=35; send 0x16, 0x29 → state IDLE, all outputs 0, no cur_load pulse.
- TIMEOUT_CYC=8; arm, then idle 8 cycles → armed falls. Separately, strobe a key on the expiry cycle → state stays armed.
